// File: rtl/fetch_pc_unit_if.sv
// Fetch front-end bus: hazard/redirect/halt controls in, imem drive
// plus fetch-stage PC, valid, sticky error flags and FSM state out.
interface fetch_pc_unit_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt;
  logic [31:0] imem_addr;
  logic        imem_we;
  logic        imem_nop;
  logic [31:0] pc_f;
  logic [31:0] pc_plus4_f;
  logic        valid_f;
  logic        misalign_err;
  logic        oob_err;
  logic [1:0]  fetch_state;

  modport master (
    input  stall,
    input  redirect_valid,
    input  redirect_target,
    input  halt,
    output imem_addr,
    output imem_we,
    output imem_nop,
    output pc_f,
    output pc_plus4_f,
    output valid_f,
    output misalign_err,
    output oob_err,
    output fetch_state
  );

  modport slave (
    output stall,
    output redirect_valid,
    output redirect_target,
    output halt,
    input  imem_addr,
    input  imem_we,
    input  imem_nop,
    input  pc_f,
    input  pc_plus4_f,
    input  valid_f,
    input  misalign_err,
    input  oob_err,
    input  fetch_state
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: owns the PC, drives imem addr/we/nop, handles stall,
// redirect+flush, halt; ports: clk, rst, bus (fetch_pc_unit_if.master).
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned IMEM_WORDS   = 512
) (
  input  logic            clk,
  input  logic            rst,
  fetch_pc_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  localparam logic [32:0] LIMIT =
    33'(IMEM_WORDS) * 33'd4;
  localparam logic [2:0] FLUSH_N =
    3'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] p4_q, p4_d;
  logic        valid_q, valid_d;
  logic        mis_q, mis_d;
  logic        oob_q, oob_d;
  logic [2:0]  cnt_q, cnt_d;

  logic [31:0] pc_inc;
  logic [31:0] tgt;
  logic        tgt_mis;
  logic        oob_now;
  logic        in_run;
  state_e      redir_st;

  // One-hot edge events, already priority-resolved
  logic        r_oob;
  logic        r_redir;
  logic        r_stall;
  logic        f_redir;

  assign pc_inc  = pc_q + 32'd4;
  assign tgt     = {bus.redirect_target[31:2],
                    2'b00};
  assign tgt_mis = |bus.redirect_target[1:0];
  assign oob_now = {1'b0, pc_q} >= LIMIT;
  assign in_run  = state_q == S_RUN;

  // Zero flush cycles means the redirect edge
  // alone squashes the wrong-path fetch
  assign redir_st = (FLUSH_N != 3'd0) ?
                    S_FLUSH : S_RUN;

  assign r_oob   = !bus.halt & oob_now;
  assign r_redir = !bus.halt & !oob_now &
                   bus.redirect_valid;
  assign r_stall = !bus.halt & !oob_now &
                   !bus.redirect_valid &
                   bus.stall;
  assign f_redir = !bus.halt &
                   bus.redirect_valid;

  assign bus.imem_addr = pc_q;

  assign bus.imem_we =
    in_run & !bus.stall &
    !bus.redirect_valid &
    !bus.halt & !oob_now;

  assign bus.imem_nop =
    (state_q == S_FLUSH) |
    (state_q == S_HALT) |
    bus.redirect_valid | bus.halt |
    (in_run & oob_now);

  assign bus.pc_f         = pcf_q;
  assign bus.pc_plus4_f   = p4_q;
  assign bus.valid_f      = valid_q;
  assign bus.misalign_err = mis_q;
  assign bus.oob_err      = oob_q;
  assign bus.fetch_state  = state_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pcf_d   = pcf_q;
    p4_d    = p4_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    oob_d   = oob_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_RESET: begin
        if (bus.halt) begin
          state_d = S_HALT;
          valid_d = 1'b0;
        end else begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        unique case (1'b1)
          bus.halt: begin
            state_d = S_HALT;
            valid_d = 1'b0;
          end
          r_oob: begin
            oob_d   = 1'b1;
            state_d = S_HALT;
            valid_d = 1'b0;
          end
          r_redir: begin
            pc_d    = tgt;
            valid_d = 1'b0;
            cnt_d   = FLUSH_N;
            state_d = redir_st;
            if (tgt_mis) mis_d = 1'b1;
          end
          r_stall: begin
          end
          default: begin
            pc_d    = pc_inc;
            pcf_d   = pc_q;
            p4_d    = pc_inc;
            valid_d = 1'b1;
          end
        endcase
      end

      S_FLUSH: begin
        valid_d = 1'b0;
        unique case (1'b1)
          bus.halt: begin
            state_d = S_HALT;
          end
          f_redir: begin
            pc_d    = tgt;
            cnt_d   = FLUSH_N;
            state_d = redir_st;
            if (tgt_mis) mis_d = 1'b1;
          end
          default: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q <= 3'd1) begin
              cnt_d   = 3'd0;
              state_d = S_RUN;
            end
          end
        endcase
      end

      S_HALT: begin
        valid_d = 1'b0;
      end

      default: begin
        state_d = S_RESET;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RESET;
      pc_q    <= RESET_PC;
      pcf_q   <= 32'd0;
      p4_q    <= 32'd4;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      oob_q   <= 1'b0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pcf_q   <= pcf_d;
      p4_q    <= p4_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      oob_q   <= oob_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed plan walk plus random traffic,
// checked each cycle against a behavioural fetch model.
module tb_fetch_pc_unit;

  localparam logic [31:0] RPC   = 32'h0;
  localparam int          NFL   = 1;
  localparam logic [31:0] LIMIT = 32'd2048;

  logic clk = 1'b0;
  logic rst = 1'b0;

  fetch_pc_unit_if bus ();

  fetch_pc_unit #(
    .RESET_PC     (RPC),
    .FLUSH_CYCLES (NFL),
    .IMEM_WORDS   (512)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: state 0 reset, 1 run, 2 flush, 3 halt
  int          m_st   = 0;
  int          m_left = 0;
  logic [31:0] m_pc   = RPC;
  logic [31:0] m_pcf  = 0;
  logic [31:0] m_p4   = 4;
  logic        m_v    = 0;
  logic        m_mis  = 0;
  logic        m_oob  = 0;

  task automatic cmp(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic model_check();
    logic oobn, run, we, nop;
    oobn = m_pc >= LIMIT;
    run  = m_st == 1;
    we   = run && !bus.stall &&
           !bus.redirect_valid &&
           !bus.halt && !oobn;
    nop  = m_st == 2 || m_st == 3 ||
           bus.redirect_valid || bus.halt ||
           (run && oobn);
    cmp("addr",  bus.imem_addr, m_pc);
    cmp("we",    32'(bus.imem_we), 32'(we));
    cmp("nop",   32'(bus.imem_nop), 32'(nop));
    cmp("pc_f",  bus.pc_f, m_pcf);
    cmp("pc4",   bus.pc_plus4_f, m_p4);
    cmp("valid", 32'(bus.valid_f), 32'(m_v));
    cmp("mis",   32'(bus.misalign_err),
                 32'(m_mis));
    cmp("oob",   32'(bus.oob_err), 32'(m_oob));
    cmp("state", 32'(bus.fetch_state),
                 32'(m_st));
  endtask

  task automatic take_redirect();
    m_pc = bus.redirect_target & ~32'h3;
    m_v  = 0;
    if (bus.redirect_target[1:0] != 0)
      m_mis = 1;
    if (NFL > 0) begin
      m_st   = 2;
      m_left = NFL;
    end else begin
      m_st = 1;
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_st = 0; m_left = 0; m_pc = RPC;
      m_pcf = 0; m_p4 = 4; m_v = 0;
      m_mis = 0; m_oob = 0;
      return;
    end
    case (m_st)
      0: m_st = bus.halt ? 3 : 1;
      1: begin
        if (bus.halt) begin
          m_st = 3; m_v = 0;
        end else if (m_pc >= LIMIT) begin
          m_oob = 1; m_st = 3; m_v = 0;
        end else if (bus.redirect_valid) begin
          take_redirect();
        end else if (!bus.stall) begin
          m_pcf = m_pc;
          m_p4  = m_pc + 4;
          m_pc  = m_pc + 4;
          m_v   = 1;
        end
      end
      2: begin
        m_v = 0;
        if (bus.halt) m_st = 3;
        else if (bus.redirect_valid)
          take_redirect();
        else begin
          m_left--;
          if (m_left <= 0) m_st = 1;
        end
      end
      default: m_v = 0;
    endcase
  endtask

  // Called at a negedge; returns at the next negedge
  task automatic step(input logic s,
                      input logic r,
                      input logic [31:0] t,
                      input logic h,
                      input logic x,
                      input bit chk = 1);
    bus.stall           = s;
    bus.redirect_valid  = r;
    bus.redirect_target = t;
    bus.halt            = h;
    rst                 = x;
    #2;
    if (chk) model_check();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.stall           = 0;
    bus.redirect_valid  = 0;
    bus.redirect_target = 0;
    bus.halt            = 0;
    @(negedge clk);

    step(0, 0, 0, 0, 1, 0);
    cmp("rst_addr",  bus.imem_addr, 32'h0);
    cmp("rst_pcf",   bus.pc_f, 32'h0);
    cmp("rst_pc4",   bus.pc_plus4_f, 32'h4);
    cmp("rst_valid", 32'(bus.valid_f), 0);
    cmp("rst_state", 32'(bus.fetch_state), 0);

    idle(1);
    cmp("run_addr0", bus.imem_addr, 32'h0);
    cmp("run_state", 32'(bus.fetch_state), 1);
    idle(1);
    cmp("pcf0", bus.pc_f, 32'h0);
    cmp("v0",   32'(bus.valid_f), 1);
    cmp("addr4", bus.imem_addr, 32'h4);
    idle(1);
    cmp("pcf4", bus.pc_f, 32'h4);
    idle(1);
    cmp("pcf8", bus.pc_f, 32'h8);
    cmp("addrC", bus.imem_addr, 32'hC);
    idle(1);

    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0);
      cmp("stall_addr", bus.imem_addr, 32'h10);
      cmp("stall_pcf",  bus.pc_f, 32'hC);
    end
    idle(1);
    cmp("res_10", bus.pc_f, 32'h10);
    idle(1);
    cmp("res_14", bus.pc_f, 32'h14);
    idle(2);
    cmp("at_20", bus.imem_addr, 32'h20);

    step(1, 1, 32'h40, 0, 0);
    cmp("rd_v",  32'(bus.valid_f), 0);
    cmp("rd_st", 32'(bus.fetch_state), 2);
    idle(1);
    cmp("fl_v",  32'(bus.valid_f), 0);
    idle(1);
    cmp("rd_40", bus.pc_f, 32'h40);
    idle(1);
    cmp("rd_44", bus.pc_f, 32'h44);

    step(0, 1, 32'h42, 0, 0);
    idle(2);
    cmp("mis_40",  bus.pc_f, 32'h40);
    cmp("mis_set", 32'(bus.misalign_err), 1);

    step(0, 1, 32'h7FC, 0, 0);
    idle(2);
    cmp("edge_pcf", bus.pc_f, 32'h7FC);
    cmp("edge_v",   32'(bus.valid_f), 1);
    cmp("edge_pc",  bus.imem_addr, 32'h800);
    idle(1);
    cmp("oob_set", 32'(bus.oob_err), 1);
    cmp("oob_st",  32'(bus.fetch_state), 3);
    #2 cmp("oob_nop", 32'(bus.imem_nop), 1);
    cmp("mis_keep", 32'(bus.misalign_err), 1);
    idle(2);
    step(0, 0, 0, 0, 1);
    cmp("rst2_st",  32'(bus.fetch_state), 0);
    cmp("rst2_mis", 32'(bus.misalign_err), 0);
    cmp("rst2_oob", 32'(bus.oob_err), 0);

    idle(3);
    step(1, 1, 32'h100, 1, 0);
    cmp("halt_st", 32'(bus.fetch_state), 3);
    cmp("halt_pc", bus.imem_addr, 32'h8);
    step(0, 0, 0, 0, 1);
    cmp("rst3_st", 32'(bus.fetch_state), 0);
    cmp("rst3_pc", bus.imem_addr, RPC);

    for (int i = 0; i < 4000; i++) begin
      logic s, r, h, x;
      logic [31:0] t;
      s = $urandom_range(0, 99) < 20;
      r = $urandom_range(0, 99) < 10;
      h = $urandom_range(0, 199) < 1;
      x = $urandom_range(0, 99) < 2;
      case ($urandom_range(0, 3))
        0: t = 32'h7E0 + $urandom_range(0, 63);
        1: t = $urandom_range(0, 1023);
        2: t = $urandom;
        default: t = $urandom_range(0, 255) << 2;
      endcase
      step(s, r, t, h, x);
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the instruction memory.
- Owns the program counter and drives the memory's address, read-enable and nop-inject inputs.
- Applies stall, branch/jump redirect with flush, and halt.
- Emits the PC and a valid flag cycle-aligned with the instruction the memory presents to decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FLUSH_CYCLES, 1, extra nop-inject cycles after the redirect edge (range 0-7).
- IMEM_WORDS, 512, instruction memory depth in 32-bit words; bounds check limit = IMEM_WORDS*4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit hold request.
- redirect_valid  in  1  taken branch/jump from EX.
- redirect_target  in  32  new fetch byte address.
- halt  in  1  stop fetching until reset.
- imem_addr  out  32  byte address to instruction memory (registered PC).
- imem_we  out  1  fetch enable to instruction memory (combinational).
- imem_nop  out  1  nop-inject request to instruction memory (combinational).
- pc_f  out  32  PC of instruction currently output by instruction memory.
- pc_plus4_f  out  32  pc_f + 4, for JAL/JALR link.
- valid_f  out  1  instruction memory output is a real fetched instruction.
- misalign_err  out  1  sticky: redirect target had [1:0] != 0.
- oob_err  out  1  sticky: fetch attempted at address >= IMEM_WORDS*4.
- fetch_state  out  2  RESET=0, RUN=1, FLUSH=2, HALT=3.

Behaviour:
- Reset (rst=1 at edge, overrides everything):
  - pc=RESET_PC, pc_f=0, pc_plus4_f=4, valid_f=0.
  - Both error flags cleared; flush counter=0; state=RESET.
- imem_addr = pc register.
- imem_we = (state==RUN) & !stall & !redirect_valid & !halt & !oob_now, where oob_now = (pc >= IMEM_WORDS*4).
- imem_nop = (state==FLUSH) | (state==HALT) | redirect_valid | halt | (state==RUN & oob_now).
- Timing: the instruction memory samples addr/we/nop at the same edge that pc updates. Fetch latency is 1 cycle: the address presented before edge k appears as the instruction after edge k.
- Priority at each edge: rst > halt > oob > redirect > stall > advance.
- RESET state: next edge -> RUN; pc unchanged; imem_we=0 and imem_nop=0, so the memory output is held.
- RUN:
  - Advance: pc <= pc+4 (mod 2^32); pc_f <= pc; pc_plus4_f <= pc+4; valid_f <= 1.
  - stall=1: pc, pc_f and valid_f hold; memory holds its instruction.
  - redirect_valid=1: pc <= {redirect_target[31:2],2'b00}; valid_f <= 0. The wrong-path fetch on this edge is replaced by the memory's nop.
    - If FLUSH_CYCLES>0: counter <= FLUSH_CYCLES, state -> FLUSH. Otherwise stay in RUN.
    - If redirect_target[1:0]!=0: misalign_err <= 1.
  - oob_now=1: oob_err <= 1, state -> HALT, valid_f <= 0.
- FLUSH:
  - Nop injected every cycle; pc holds; valid_f=0; stall ignored.
  - counter decrements; at counter==1 the edge moves state -> RUN.
  - New redirect in FLUSH: load new target, reload counter to FLUSH_CYCLES.
- HALT: terminal until rst; pc holds, imem_nop=1, valid_f=0.
- Redirect and stall in the same cycle: the redirect wins.
- halt while redirect pending: HALT; the redirect is dropped.
- Reset mid-FLUSH or mid-HALT returns to the RESET state with all values above.
- Error flags are sticky; only rst clears them.

Test Plan:
- Reset release, RESET_PC=0, no stall -> imem_addr steps 0,0,4,8,C; pc_f after successive RUN edges 0,4,8; valid_f=1 from the first RUN edge.
- Stall for 3 cycles at pc=0x10 -> imem_addr stays 0x10, imem_we=0, pc_f/valid_f unchanged; fetch resumes with 0x10 then 0x14.
- Redirect to 0x40 at pc=0x20, FLUSH_CYCLES=1 -> imem_nop=1 for 2 edges, valid_f=0 for 2 cycles. Next valid pc_f=0x40, then 0x44.
- Redirect to 0x42 -> fetch resumes at 0x40, misalign_err=1, stays 1 until rst.
- Redirect to 0x7FC, IMEM_WORDS=512 -> 0x7FC fetched valid. Next cycle pc=0x800 -> oob_err=1, state=HALT, imem_nop=1 persistent.
- halt=1 simultaneously with redirect and stall -> state=HALT, pc unchanged. rst=1 later -> state RESET, pc=RESET_PC, flags 0.
